// File: rtl/io_uart_tx.sv
// io_uart_tx: host-facing end of the core's write-only IO port.
// Words strobed in by the core are buffered in a small FIFO and sent
// little-endian over an 8N1 UART line, four frames per word.
// The core never stalls, so a strobe into a full FIFO is dropped and
// recorded in a sticky overflow flag.
// Build option: define IO_UART_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11-bit frames).
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | line high; pops the next word when the FIFO is non-empty
// START  | start bit (line low) for one bit time
// DATA   | eight data bits, LSB first, one bit time each
// PARITY | even parity of the data byte (IO_UART_PARITY_EN only)
// STOP   | stop bit (line high); next byte or back to IDLE
//
// tx is registered from the current state, so the line lags the state
// register by one cycle. busy is stretched by the same cycle so that it
// drops only once the final stop bit has finished on the line.

module io_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   din,
    input  logic                          din_valid,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

`ifdef IO_UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Serializer
    state_t        r_state;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit_idx;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic [7:0]    r_byte;
    logic          r_tx;
    logic          r_line_busy;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_fifo_rdata;

    // A pop frees a slot in the same cycle, so a strobe into a full FIFO
    // is still accepted when the serializer takes a word at that edge.
    assign w_full       = (r_count == CNT_FULL);
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_push       = din_valid && (!w_full || w_pop);
    assign w_fifo_rdata = r_mem[r_rd_ptr];

    // FIFO data array; contents need no reset because the count guards reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (din_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Frame sequencer: baud down-counter, bit/byte indices and registered line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_byte      <= '0;
            r_tx        <= 1'b1;
            r_line_busy <= 1'b0;
        end else begin
            r_line_busy <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_word     <= w_fifo_rdata;
                        r_byte_idx <= '0;
                        r_baud     <= BAUD_RELOAD;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    r_tx <= 1'b0;
                    if (r_baud == '0) begin
                        r_byte    <= r_word[{r_byte_idx, 3'b000} +: 8];
                        r_bit_idx <= '0;
                        r_baud    <= BAUD_RELOAD;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end

                S_DATA: begin
                    r_tx <= r_byte[r_bit_idx];
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end

`ifdef IO_UART_PARITY_EN
                S_PARITY: begin
                    r_tx <= ^r_byte;
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_baud == '0) begin
                        if (r_byte_idx != 2'd3) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_baud     <= BAUD_RELOAD;
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) | (r_count != '0) | r_line_busy;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed steps with random payload words. A line
// decoder rebuilds bytes from tx at mid-bit and records each start-bit
// fall; expected bytes come from the accepted words split little-endian.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef IO_UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int FC = FRAME * CPB;
    localparam int WT = 4 * FC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];
    int         got_falls[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line decoder
    int               mon_cnt = 0;
    bit               mon_active = 1'b0;
    logic [FRAME-1:0] mon_bits;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_bits   = '1;
                    got_falls.push_back(cyc);
                end
            end else begin
                mon_cnt++;
            end
            if (mon_active && (mon_cnt % CPB) == CPB / 2) begin
                mon_bits[mon_cnt / CPB] = tx;
                if (mon_cnt / CPB == FRAME - 1) begin
                    check("frame start bit", mon_bits[0], 1'b0);
                    check("frame stop bit", mon_bits[FRAME-1], 1'b1);
`ifdef IO_UART_PARITY_EN
                    check("frame parity bit", mon_bits[9], ^mon_bits[8:1]);
`endif
                    got_bytes.push_back(mon_bits[8:1]);
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Called just after a negedge; the values are sampled at the next posedge
    task automatic step(input logic v, input logic [31:0] w);
        din_valid = v;
        din       = w;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
    endtask

    task automatic drain(input string tag, input bit chk_falls);
        int k = 0;
        while (busy !== 1'b0 && k < 10 * WT) begin
            step(1'b0, 32'h0);
            k++;
        end
        check({tag, " idle"}, busy, 1'b0);
        check({tag, " nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check($sformatf("%s byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
        if (chk_falls)
            for (int i = 1; i < got_falls.size(); i++)
                check($sformatf("%s spacing%0d", tag, i), got_falls[i] - got_falls[i-1],
                      (i % 4 == 0) ? FC + 1 : FC);
        got_bytes.delete();
        exp_bytes.delete();
        got_falls.delete();
    endtask

    logic [31:0] w, w2;
    logic [31:0] wq[6];
    int          k, p;

    initial begin
        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b0;
        #1;
        check("rst tx", tx, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst overflow", overflow, 1'b0);
        check("rst count", fifo_count, 3'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single word: latency, byte order, frame length, busy length
        w = 32'h12345678;
        expect_word(w);
        step(1'b1, w);
        p = cyc;
        check("t1 count after push", fifo_count, 3'd1);
        check("t1 busy after push", busy, 1'b1);
        check("t1 tx after push", tx, 1'b1);
        step(1'b0, 32'h0);
        check("t1 count after pop", fifo_count, 3'd0);
        check("t1 tx at pop", tx, 1'b1);
        step(1'b0, 32'h0);
        check("t1 tx fall", tx, 1'b0);
        k = 0;
        while (busy !== 1'b0 && k < 2 * WT) begin
            step(1'b0, 32'h0);
            k++;
        end
        check("t1 busy length", k, WT);
        check("t1 fall latency", (got_falls.size() > 0) ? got_falls[0] - p : -1, 2);
        drain("t1", 1'b1);

        // Back-to-back strobes
        step(1'b1, 32'h1);
        check("t2 count0", fifo_count, 3'd1);
        step(1'b1, 32'h2);
        check("t2 count1", fifo_count, 3'd1);
        step(1'b1, 32'h3);
        check("t2 count2", fifo_count, 3'd2);
        step(1'b0, 32'h0);
        check("t2 count peak", fifo_count, 3'd2);
        expect_word(32'h1);
        expect_word(32'h2);
        expect_word(32'h3);
        drain("t2", 1'b1);
        check("t2 overflow", overflow, 1'b0);

        // Push coinciding with pop while full
        for (int i = 0; i < 6; i++) begin
            wq[i] = $urandom;
            expect_word(wq[i]);
        end
        for (int i = 0; i < 5; i++) step(1'b1, wq[i]);
        check("t4 full", fifo_count, 3'd4);
        repeat (WT - 3) step(1'b0, 32'h0);
        check("t4 full before pop", fifo_count, 3'd4);
        check("t4 overflow before", overflow, 1'b0);
        step(1'b1, wq[5]);
        check("t4 count at push+pop", fifo_count, 3'd4);
        check("t4 overflow at push+pop", overflow, 1'b0);
        drain("t4", 1'b1);

        // Overflow: sixth strobe dropped
        for (int i = 0; i < 6; i++) begin
            wq[i] = $urandom;
            if (i < 5) expect_word(wq[i]);
        end
        for (int i = 0; i < 5; i++) step(1'b1, wq[i]);
        check("t3 count full", fifo_count, 3'd4);
        check("t3 overflow before drop", overflow, 1'b0);
        step(1'b1, wq[5]);
        check("t3 count after drop", fifo_count, 3'd4);
        check("t3 overflow set", overflow, 1'b1);
        drain("t3", 1'b1);
        check("t3 overflow sticky", overflow, 1'b1);

        // Reset during data bit 3 of the second byte
        w  = $urandom;
        w2 = $urandom;
        step(1'b1, w);
        step(1'b1, w2);
        repeat (2 + FC + 4 * CPB) step(1'b0, 32'h0);
        check("t5 tx bit3 byte1", tx, w[11]);
        check("t5 count before reset", fifo_count, 3'd1);
        #1 reset = 1'b0;
        #1;
        check("t5 rst tx", tx, 1'b1);
        check("t5 rst busy", busy, 1'b0);
        check("t5 rst count", fifo_count, 3'd0);
        check("t5 rst overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        got_bytes.delete();
        exp_bytes.delete();
        got_falls.delete();
        expect_word(32'hA5A5A5A5);
        step(1'b1, 32'hA5A5A5A5);
        drain("t5", 1'b1);

        // Parity-sensitive payload
        expect_word(32'h00000007);
        step(1'b1, 32'h00000007);
        drain("t6", 1'b1);

        // Random words with short random gaps; never enough to fill the FIFO
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            expect_word(w);
            step(1'b1, w);
            repeat ($urandom_range(0, 3)) step(1'b0, 32'h0);
        end
        drain("t7", 1'b1);
        check("t7 overflow", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
